// File: rtl/cachepool_pkg.sv
// Shared CachePool DRAM decode helpers: default channel geometry plus the
// channel-select and address-scramble functions, so every master that talks
// to the DRAM channels decodes addresses identically.
package cachepool_pkg;

  localparam int unsigned NumL2Channel  = 4;
  localparam int unsigned L2BankBeWidth = 64;
  localparam int unsigned Interleave    = 128;
  localparam logic [31:0] DramPerChSize = 32'h1000_0000;

  // Helpers work on a wide address so any AddrWidth up to 64 can reuse them.
  localparam int unsigned MaxAddrWidth = 64;
  typedef logic [MaxAddrWidth-1:0] wide_addr_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Channel index taken from the interleave bits just above the constant block.
  function automatic wide_addr_t chan_select(input wide_addr_t addr,
                                             input int unsigned cb,
                                             input int unsigned sb);
    wide_addr_t mask;
    mask = (wide_addr_t'(1) << sb) - wide_addr_t'(1);
    return (addr >> cb) & mask;
  endfunction

  // Channel-local address: channel bits move up to just below the untouched
  // top bits, and the in-channel block index closes the gap they left.
  function automatic wide_addr_t scramble(input wide_addr_t addr,
                                          input int unsigned cb,
                                          input int unsigned sb,
                                          input int unsigned size_bits);
    wide_addr_t low_mask;
    wide_addr_t mid_mask;
    wide_addr_t hi_mask;
    wide_addr_t sel;
    low_mask = (wide_addr_t'(1) << cb) - wide_addr_t'(1);
    mid_mask = (wide_addr_t'(1) << (size_bits - cb)) - wide_addr_t'(1);
    hi_mask  = ~((wide_addr_t'(1) << (size_bits + sb)) - wide_addr_t'(1));
    sel      = chan_select(addr, cb, sb);
    return (addr & hi_mask) | (sel << size_bits) |
           (((addr >> (cb + sb)) & mid_mask) << cb) | (addr & low_mask);
  endfunction

endpackage

// File: rtl/cachepool_dram_rsp_arb.sv
// Locked round-robin merge of per-channel read-response bursts into a single
// stream. A channel keeps the grant from its first offered beat until its
// last beat handshakes, so bursts never interleave.
module cachepool_dram_rsp_arb
  import cachepool_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned IdWidth     = 6,
  parameter int unsigned DataWidth   = 128
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           chan_rsp_valid_i,
  output logic [NumChannels-1:0]           chan_rsp_ready_o,
  input  logic [NumChannels*DataWidth-1:0] chan_rsp_data_i,
  input  logic [NumChannels*IdWidth-1:0]   chan_rsp_id_i,
  input  logic [NumChannels-1:0]           chan_rsp_last_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DataWidth-1:0]             rsp_data_o,
  output logic [IdWidth-1:0]               rsp_id_o,
  output logic                             rsp_last_o
);

  localparam int unsigned SB = $clog2(NumChannels);

  arb_state_e    state_q, state_d;
  logic [SB-1:0] ptr_q, ptr_d;
  logic [SB-1:0] lock_q, lock_d;
  logic [SB-1:0] gnt;
  logic [SB-1:0] idx;
  logic          gnt_valid;

  // Grant: the locked channel, otherwise the first valid channel from the pointer.
  always_comb begin
    gnt       = lock_q;
    gnt_valid = 1'b0;
    idx       = '0;
    if (state_q == ARB_LOCKED) begin
      gnt_valid = chan_rsp_valid_i[lock_q];
    end else begin
      for (int i = NumChannels - 1; i >= 0; i--) begin
        idx = ptr_q + SB'(i);
        if (chan_rsp_valid_i[idx]) begin
          gnt       = idx;
          gnt_valid = 1'b1;
        end
      end
    end
  end

  // Next state: hold the grant until the last beat, then rotate past it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (gnt_valid) begin
      if (rsp_ready_i && chan_rsp_last_i[gnt]) begin
        state_d = ARB_IDLE;
        ptr_d   = gnt + SB'(1);
      end else begin
        state_d = ARB_LOCKED;
        lock_d  = gnt;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Steer the granted channel to the merged output and back-pressure only it.
  always_comb begin
    chan_rsp_ready_o = '0;
    if (gnt_valid) chan_rsp_ready_o[gnt] = rsp_ready_i;
    rsp_valid_o = gnt_valid;
    rsp_data_o  = chan_rsp_data_i[gnt*DataWidth +: DataWidth];
    rsp_id_o    = chan_rsp_id_i[gnt*IdWidth +: IdWidth];
    rsp_last_o  = chan_rsp_last_i[gnt];
  end

endmodule

// File: rtl/cachepool_dram_rd_router.sv
// Routes CachePool L1 refill reads to the DRAM channels selected by the
// interleave bits and merges the channel responses back into one stream.
// A per-ID table keeps each ID's outstanding bursts on a single channel so
// its responses return in order.
// Build option: CACHEPOOL_DRAM_SCRAMBLE_EN rewrites the outgoing address into
// channel-local form; otherwise the address passes through unchanged.
module cachepool_dram_rd_router #(
  parameter int unsigned     NumChannels = cachepool_pkg::NumL2Channel,
  parameter int unsigned     AddrWidth   = 32,
  parameter int unsigned     IdWidth     = 6,
  parameter int unsigned     DataWidth   = 128,
  parameter int unsigned     ChanBeBytes = cachepool_pkg::L2BankBeWidth,
  parameter int unsigned     Interleave  = cachepool_pkg::Interleave,
  parameter longint unsigned ChanSize    = 64'(cachepool_pkg::DramPerChSize),
  parameter int unsigned     MaxTxnPerId = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [AddrWidth-1:0]             req_addr_i,
  input  logic [IdWidth-1:0]               req_id_i,
  input  logic [7:0]                       req_len_i,
  output logic [NumChannels-1:0]           chan_req_valid_o,
  input  logic [NumChannels-1:0]           chan_req_ready_i,
  output logic [AddrWidth-1:0]             chan_req_addr_o,
  output logic [IdWidth-1:0]               chan_req_id_o,
  output logic [7:0]                       chan_req_len_o,
  input  logic [NumChannels-1:0]           chan_rsp_valid_i,
  output logic [NumChannels-1:0]           chan_rsp_ready_o,
  input  logic [NumChannels*DataWidth-1:0] chan_rsp_data_i,
  input  logic [NumChannels*IdWidth-1:0]   chan_rsp_id_i,
  input  logic [NumChannels-1:0]           chan_rsp_last_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DataWidth-1:0]             rsp_data_o,
  output logic [IdWidth-1:0]               rsp_id_o,
  output logic                             rsp_last_o
);

  import cachepool_pkg::*;

  localparam int unsigned CB     = $clog2(ChanBeBytes * Interleave);
  localparam int unsigned SB     = $clog2(NumChannels);
  localparam int unsigned CntW   = $clog2(MaxTxnPerId + 1);
  localparam int unsigned NumIds = 1 << IdWidth;

  if (NumChannels < 2 || (NumChannels & (NumChannels - 1)) != 0 ||
      (ChanSize & (ChanSize - 1)) != 0) begin : g_bad_cfg
    $error("NumChannels and ChanSize must be powers of two, NumChannels >= 2");
  end

  wide_addr_t      addr_wide;
  wide_addr_t      sel_wide;
  wide_addr_t      addr_map;
  logic [SB-1:0]   sel;
  logic [CntW-1:0] cnt_q  [NumIds];
  logic [SB-1:0]   chan_q [NumIds];
  logic            eligible;
  logic            req_hs;
  logic            ret_hs;
  logic            same_id;
  logic            unused_addr_hi;

  assign addr_wide = wide_addr_t'(req_addr_i);
  assign sel_wide  = chan_select(addr_wide, CB, SB);
  assign sel       = sel_wide[SB-1:0];

`ifdef CACHEPOOL_DRAM_SCRAMBLE_EN
  localparam int unsigned SizeBits = $clog2(ChanSize);
  if (longint'(ChanBeBytes * Interleave) < ChanSize) begin : g_scramble
    assign addr_map = scramble(addr_wide, CB, SB, SizeBits);
  end else begin : g_flat
    assign addr_map = addr_wide;
  end
`else
  assign addr_map = addr_wide;
`endif

  assign unused_addr_hi  = ^{addr_map[MaxAddrWidth-1:AddrWidth], sel_wide[MaxAddrWidth-1:SB]};
  assign chan_req_addr_o = addr_map[AddrWidth-1:0];
  assign chan_req_id_o   = req_id_i;
  assign chan_req_len_o  = req_len_i;

  // An ID may issue when idle, or when it stays on its current channel below the cap.
  assign eligible = (cnt_q[req_id_i] == '0) ||
                    ((chan_q[req_id_i] == sel) && (cnt_q[req_id_i] < CntW'(MaxTxnPerId)));

  // Zero-latency dispatch to the decoded channel; stalled requests raise nothing.
  always_comb begin
    chan_req_valid_o = '0;
    if (eligible && req_valid_i) chan_req_valid_o[sel] = 1'b1;
    req_ready_o = eligible && chan_req_ready_i[sel];
  end

  assign req_hs  = req_valid_i && req_ready_o;
  assign ret_hs  = rsp_valid_o && rsp_ready_i && rsp_last_o;
  assign same_id = req_hs && ret_hs && (rsp_id_o == req_id_i);

  // Per-ID outstanding count and channel; an accept and retire of one ID cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i]  <= '0;
        chan_q[i] <= '0;
      end
    end else begin
      if (req_hs) begin
        chan_q[req_id_i] <= sel;
        if (!same_id) cnt_q[req_id_i] <= cnt_q[req_id_i] + CntW'(1);
      end
      if (ret_hs && !same_id && cnt_q[rsp_id_o] != '0) begin
        cnt_q[rsp_id_o] <= cnt_q[rsp_id_o] - CntW'(1);
      end
    end
  end

  // A burst retiring for an ID with nothing outstanding is a channel protocol error.
  assert property (@(posedge clk_i) disable iff (rst_i) ret_hs |-> (cnt_q[rsp_id_o] != '0));

  cachepool_dram_rsp_arb #(
    .NumChannels (NumChannels),
    .IdWidth     (IdWidth),
    .DataWidth   (DataWidth)
  ) i_rsp_arb (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .chan_rsp_valid_i (chan_rsp_valid_i),
    .chan_rsp_ready_o (chan_rsp_ready_o),
    .chan_rsp_data_i  (chan_rsp_data_i),
    .chan_rsp_id_i    (chan_rsp_id_i),
    .chan_rsp_last_i  (chan_rsp_last_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_id_o         (rsp_id_o),
    .rsp_last_o       (rsp_last_o)
  );

endmodule

// File: tb/tb_cachepool_dram_rd_router.sv
// Bench for cachepool_dram_rd_router: directed refill/response scenarios with
// a behavioural model of routing, per-ID ordering and response merging.
`timescale 1ns/1ps
module tb_cachepool_dram_rd_router;

  localparam int NC   = 4;
  localparam int AW   = 32;
  localparam int IW   = 6;
  localparam int DW   = 128;
  localparam int MAXT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready_o;
  logic [AW-1:0]    req_addr;
  logic [IW-1:0]    req_id;
  logic [7:0]       req_len;
  logic [NC-1:0]    chan_req_valid_o;
  logic [NC-1:0]    chan_req_ready;
  logic [AW-1:0]    chan_req_addr_o;
  logic [IW-1:0]    chan_req_id_o;
  logic [7:0]       chan_req_len_o;
  logic [NC-1:0]    chan_rsp_valid;
  logic [NC-1:0]    chan_rsp_ready_o;
  logic [NC*DW-1:0] chan_rsp_data;
  logic [NC*IW-1:0] chan_rsp_id;
  logic [NC-1:0]    chan_rsp_last;
  logic             rsp_valid_o;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data_o;
  logic [IW-1:0]    rsp_id_o;
  logic             rsp_last_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cachepool_dram_rd_router dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr),
    .req_id_i         (req_id),
    .req_len_i        (req_len),
    .chan_req_valid_o (chan_req_valid_o),
    .chan_req_ready_i (chan_req_ready),
    .chan_req_addr_o  (chan_req_addr_o),
    .chan_req_id_o    (chan_req_id_o),
    .chan_req_len_o   (chan_req_len_o),
    .chan_rsp_valid_i (chan_rsp_valid),
    .chan_rsp_ready_o (chan_rsp_ready_o),
    .chan_rsp_data_i  (chan_rsp_data),
    .chan_rsp_id_i    (chan_rsp_id),
    .chan_rsp_last_i  (chan_rsp_last),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_data_o       (rsp_data_o),
    .rsp_id_o         (rsp_id_o),
    .rsp_last_o       (rsp_last_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt  [64];
  int m_chan [64];
  int m_ptr;
  bit m_locked;
  int m_lock_ch;

  // 8 KiB interleave blocks (64 B beats x 128) rotate over the 4 channels.
  function automatic int m_sel(input logic [31:0] a);
    return int'((a / 32'd8192) % 32'd4);
  endfunction

  function automatic bit m_elig(input int id, input int s);
    return (m_cnt[id] == 0) || (m_chan[id] == s && m_cnt[id] < MAXT);
  endfunction

  // Channel-local address: keep bits above 2^30, put channel at 2^28,
  // drop the block index (bits 15+) down to bit 13, keep the 8 KiB offset.
  function automatic logic [31:0] m_addr(input logic [31:0] a);
`ifdef CACHEPOOL_DRAM_SCRAMBLE_EN
    longint unsigned x;
    longint unsigned r;
    x = longint'(a);
    r = (x / 64'd1073741824) * 64'd1073741824 + longint'(m_sel(a)) * 64'd268435456 +
        ((x / 64'd32768) % 64'd32768) * 64'd8192 + (x % 64'd8192);
    return r[31:0];
`else
    return a;
`endif
  endfunction

  function automatic int m_grant();
    if (m_locked) return m_lock_ch;
    for (int i = 0; i < NC; i++) begin
      if (chan_rsp_valid[(m_ptr + i) % NC]) return (m_ptr + i) % NC;
    end
    return -1;
  endfunction

  int            cs, cg;
  bit            ce, cgv;
  logic [NC-1:0] cexp;

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      cs   = m_sel(req_addr);
      ce   = m_elig(int'(req_id), cs);
      cg   = m_grant();
      cgv  = (cg >= 0) && chan_rsp_valid[cg];
      cexp = '0;
      if (ce && req_valid) cexp[cs] = 1'b1;
      check("m_req_ready", 128'(req_ready_o), 128'(ce && chan_req_ready[cs]));
      check("m_chan_req_valid", 128'(chan_req_valid_o), 128'(cexp));
      if (req_valid) begin
        check("m_chan_req_addr", 128'(chan_req_addr_o), 128'(m_addr(req_addr)));
        check("m_chan_req_id", 128'(chan_req_id_o), 128'(req_id));
        check("m_chan_req_len", 128'(chan_req_len_o), 128'(req_len));
      end
      check("m_rsp_valid", 128'(rsp_valid_o), 128'(cgv));
      cexp = '0;
      if (cgv) cexp[cg] = rsp_ready;
      check("m_chan_rsp_ready", 128'(chan_rsp_ready_o), 128'(cexp));
      if (cgv) begin
        check("m_rsp_data", 128'(rsp_data_o), 128'(chan_rsp_data[cg*DW +: DW]));
        check("m_rsp_id", 128'(rsp_id_o), 128'(chan_rsp_id[cg*IW +: IW]));
        check("m_rsp_last", 128'(rsp_last_o), 128'(chan_rsp_last[cg]));
      end
    end
  end

  int us, ug, rid;
  bit ue, ugv, ureq, uret;

  // Advance the model on each clock from the stimulus and its own expectations.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_cnt[i]  = 0;
        m_chan[i] = 0;
      end
      m_ptr = 0; m_locked = 0; m_lock_ch = 0;
    end else begin
      us   = m_sel(req_addr);
      ue   = m_elig(int'(req_id), us);
      ug   = m_grant();
      ugv  = (ug >= 0) && chan_rsp_valid[ug];
      ureq = req_valid && ue && chan_req_ready[us];
      uret = ugv && rsp_ready && chan_rsp_last[ug];
      rid  = ugv ? int'(chan_rsp_id[ug*IW +: IW]) : 0;
      if (ureq) begin
        m_cnt[int'(req_id)]++;
        m_chan[int'(req_id)] = us;
      end
      if (uret && m_cnt[rid] > 0) m_cnt[rid]--;
      if (ugv) begin
        if (rsp_ready && chan_rsp_last[ug]) begin
          m_locked = 0;
          m_ptr    = (ug + 1) % NC;
        end else begin
          m_locked  = 1;
          m_lock_ch = ug;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_addr = '0; req_id = '0; req_len = '0; chan_req_ready = '0;
    chan_rsp_valid = '0; chan_rsp_data = '0; chan_rsp_id = '0; chan_rsp_last = '0;
    rsp_ready = 0;
  endtask

  task automatic issue(input int id, input logic [31:0] addr);
    req_valid = 1; req_addr = addr; req_id = IW'(id); req_len = 8'd3; chan_req_ready = '1;
    #1;
    check("issue_ready", 128'(req_ready_o), 128'(1'b1));
    step();
    req_valid = 0; chan_req_ready = '0;
  endtask

  task automatic set_beat(input int ch, input int id, input bit last, input logic [127:0] data);
    chan_rsp_valid = '0; chan_rsp_last = '0;
    chan_rsp_valid[ch] = 1'b1;
    chan_rsp_last[ch]  = last;
    chan_rsp_id[ch*IW +: IW] = IW'(id);
    chan_rsp_data[ch*DW +: DW] = data;
    rsp_ready = 1;
  endtask

  task automatic clear_beat();
    chan_rsp_valid = '0; chan_rsp_last = '0; rsp_ready = 0;
  endtask

  task automatic beat(input int ch, input int id, input bit last, input logic [127:0] data);
    logic [NC-1:0] onehot;
    onehot = '0;
    onehot[ch] = 1'b1;
    set_beat(ch, id, last, data);
    #1;
    check("beat_ready", 128'(chan_rsp_ready_o), 128'(onehot));
    step();
    clear_beat();
  endtask

  int            b_left [NC];
  int            b_id   [NC];
  int            got_id [$];
  logic [127:0]  got_data [$];

  // Offer bursts on several channels at once and log the merged stream.
  task automatic run_bursts(input int budget);
    int cyc;
    int left;
    cyc = 0;
    got_id.delete();
    got_data.delete();
    rsp_ready = 1;
    left = b_left[0] + b_left[1] + b_left[2] + b_left[3];
    while (left > 0 && cyc < budget) begin
      for (int c = 0; c < NC; c++) begin
        chan_rsp_valid[c] = (b_left[c] > 0);
        chan_rsp_last[c]  = (b_left[c] == 1);
        chan_rsp_id[c*IW +: IW]   = IW'(b_id[c]);
        chan_rsp_data[c*DW +: DW] = 128'(c * 256 + b_left[c]);
      end
      #1;
      if (rsp_valid_o && rsp_ready) begin
        got_id.push_back(int'(rsp_id_o));
        got_data.push_back(rsp_data_o);
      end
      for (int c = 0; c < NC; c++) begin
        if (chan_rsp_ready_o[c] && chan_rsp_valid[c]) b_left[c]--;
      end
      step();
      cyc++;
      left = b_left[0] + b_left[1] + b_left[2] + b_left[3];
    end
    check("bursts_done", 128'(left), 128'(0));
    clear_beat();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int exp_ids [8];
    logic [127:0] exp_dat [8];
    exp_ids = '{10, 10, 10, 10, 11, 11, 11, 11};
    exp_dat = '{128'h104, 128'h103, 128'h102, 128'h101, 128'h304, 128'h303, 128'h302, 128'h301};

    idle_inputs();
    rst = 1;
    repeat (3) step();
    rst = 0;
    #1;
    check("reset_req_ready", 128'(req_ready_o), 128'(1'b0));
    check("reset_chan_req_valid", 128'(chan_req_valid_o), 128'(4'b0000));
    check("reset_chan_rsp_ready", 128'(chan_rsp_ready_o), 128'(4'b0000));
    check("reset_rsp_valid", 128'(rsp_valid_o), 128'(1'b0));
    step();

    // Address decode / scramble: 0x8000_2000 lands on channel 1.
    req_valid = 1; req_addr = 32'h8000_2000; req_id = 6'd3; req_len = 8'd1; chan_req_ready = '0;
    #1;
    check("sel_ch1", 128'(chan_req_valid_o), 128'(4'b0010));
`ifdef CACHEPOOL_DRAM_SCRAMBLE_EN
    check("addr_map", 128'(chan_req_addr_o), 128'(32'h9000_0000));
`else
    check("addr_map", 128'(chan_req_addr_o), 128'(32'h8000_2000));
`endif
    check("wait_chan_ready", 128'(req_ready_o), 128'(1'b0));
    step();
    chan_req_ready = 4'b0010;
    #1;
    check("chan_ready_passthru", 128'(req_ready_o), 128'(1'b1));
    step();
    idle_inputs();
    beat(1, 3, 1, 128'h33);

    // Same ID on another channel waits for the first channel to drain.
    issue(5, 32'h8000_0000);
    req_valid = 1; req_addr = 32'h8000_2000; req_id = 6'd5; chan_req_ready = '1;
    #1;
    check("id5_stall_ready", 128'(req_ready_o), 128'(1'b0));
    check("id5_stall_valid", 128'(chan_req_valid_o), 128'(4'b0000));
    step();
    step();
    set_beat(0, 5, 1, 128'h55);
    #1;
    check("id5_stall_during_retire", 128'(req_ready_o), 128'(1'b0));
    step();
    clear_beat();
    #1;
    check("id5_released", 128'(req_ready_o), 128'(1'b1));
    check("id5_released_ch1", 128'(chan_req_valid_o), 128'(4'b0010));
    step();
    idle_inputs();
    beat(1, 5, 1, 128'h56);

    // Per-ID cap of eight outstanding bursts.
    for (int i = 0; i < 8; i++) issue(2, 32'h8000_0000);
    req_valid = 1; req_addr = 32'h8000_0000; req_id = 6'd2; chan_req_ready = '1;
    #1;
    check("ninth_stall", 128'(req_ready_o), 128'(1'b0));
    step();
    set_beat(0, 2, 1, 128'h20);
    step();
    clear_beat();
    #1;
    check("ninth_accept", 128'(req_ready_o), 128'(1'b1));
    step();
    idle_inputs();
    for (int i = 0; i < 8; i++) beat(0, 2, 1, 128'(32'h200 + i));

    // Two simultaneous 4-beat bursts merge without interleaving.
    issue(10, 32'h0000_2000);
    issue(11, 32'h0000_6000);
    b_left = '{0, 4, 0, 4};
    b_id   = '{0, 10, 0, 11};
    run_bursts(40);
    check("merge_count", 128'(got_id.size()), 128'(8));
    if (got_id.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("merge_id", 128'(got_id[i]), 128'(exp_ids[i]));
        check("merge_data", got_data[i], exp_dat[i]);
      end
    end

    // Pointer back at 0: channel 0 wins over channel 3.
    issue(12, 32'h0000_0000);
    issue(13, 32'h0000_6000);
    b_left = '{1, 0, 0, 1};
    b_id   = '{12, 0, 0, 13};
    run_bursts(10);
    check("ptr_count", 128'(got_id.size()), 128'(2));
    if (got_id.size() == 2) begin
      check("ptr_first", 128'(got_id[0]), 128'(12));
      check("ptr_second", 128'(got_id[1]), 128'(13));
    end

    // Accept and retire of id 7 in the same cycle leaves one outstanding.
    issue(7, 32'h0000_4000);
    req_valid = 1; req_addr = 32'h0000_4000; req_id = 6'd7; chan_req_ready = '1;
    set_beat(2, 7, 1, 128'h77);
    #1;
    check("id7_accept", 128'(req_ready_o), 128'(1'b1));
    check("id7_retire", 128'(chan_rsp_ready_o), 128'(4'b0100));
    step();
    idle_inputs();
    req_valid = 1; req_addr = 32'h0000_0000; req_id = 6'd7; chan_req_ready = '1;
    #1;
    check("id7_cnt_kept", 128'(req_ready_o), 128'(1'b0));
    step();
    set_beat(2, 7, 1, 128'h78);
    step();
    clear_beat();
    #1;
    check("id7_drained", 128'(req_ready_o), 128'(1'b1));
    step();
    idle_inputs();
    beat(0, 7, 1, 128'h79);

    // Reset in the middle of a burst with three id-4 bursts outstanding.
    for (int i = 0; i < 3; i++) issue(4, 32'h0000_2000);
    set_beat(1, 4, 0, 128'h41);
    step();
    idle_inputs();
    rst = 1;
    #1;
    check("rst_req_ready", 128'(req_ready_o), 128'(1'b0));
    check("rst_chan_req_valid", 128'(chan_req_valid_o), 128'(4'b0000));
    check("rst_chan_rsp_ready", 128'(chan_rsp_ready_o), 128'(4'b0000));
    check("rst_rsp_valid", 128'(rsp_valid_o), 128'(1'b0));
    step();
    step();
    rst = 0;
    #1;
    req_valid = 1; req_addr = 32'h0000_6000; req_id = 6'd4; chan_req_ready = '1;
    #1;
    check("post_rst_accept", 128'(req_ready_o), 128'(1'b1));
    check("post_rst_ch3", 128'(chan_req_valid_o), 128'(4'b1000));
    step();
    idle_inputs();
    issue(20, 32'h0000_0000);
    beat(0, 20, 1, 128'h2020);
    beat(3, 4, 1, 128'h4040);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
